// File: rtl/mmio_port.sv
// Memory-mapped I/O responder for the 0x800-0xFFF window: TX/RX word FIFOs
// bridging the core bus to host valid/ready streams, plus a sticky halt flag.
module mmio_port #(
  parameter int unsigned TX_DEPTH = 4,
  parameter int unsigned RX_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] data_in,
  input  logic        we,
  output logic [31:0] data_out,
  output logic        hit,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [31:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        halted
);

  localparam int unsigned TX_AW = $clog2(TX_DEPTH);
  localparam int unsigned RX_AW = $clog2(RX_DEPTH);
  localparam int unsigned TX_PW = TX_AW + 1;
  localparam int unsigned RX_PW = RX_AW + 1;

  localparam logic [9:0] REG_TX_DATA = 10'h200;
  localparam logic [9:0] REG_STATUS  = 10'h201;
  localparam logic [9:0] REG_RX_DATA = 10'h202;
  localparam logic [9:0] REG_RX_CTRL = 10'h203;
  localparam logic [9:0] REG_HALT    = 10'h3FF;

  logic [31:0]      tx_mem [TX_DEPTH];
  logic [31:0]      rx_mem [RX_DEPTH];
  logic [TX_AW:0]   tx_wp, tx_rp;
  logic [RX_AW:0]   rx_wp, rx_rp;
  logic             tx_ovf;
  logic             tx_empty, tx_full, rx_empty, rx_full;
  logic             wr_tx, wr_ctrl, wr_halt;
  logic             tx_push, tx_pop, rx_push, rx_pop;
  logic [31:0]      rx_head;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^{address[31:12], address[1:0]};

  // Occupancy flags from the extra pointer MSB
  assign tx_empty = (tx_wp == tx_rp);
  assign tx_full  = (tx_wp[TX_AW] != tx_rp[TX_AW]) &&
                    (tx_wp[TX_AW-1:0] == tx_rp[TX_AW-1:0]);
  assign rx_empty = (rx_wp == rx_rp);
  assign rx_full  = (rx_wp[RX_AW] != rx_rp[RX_AW]) &&
                    (rx_wp[RX_AW-1:0] == rx_rp[RX_AW-1:0]);

  assign hit      = address[11];
  assign wr_tx    = we && hit && (address[11:2] == REG_TX_DATA);
  assign wr_ctrl  = we && hit && (address[11:2] == REG_RX_CTRL);
  assign wr_halt  = we && hit && (address[11:2] == REG_HALT);

  // Full/empty are judged on pre-edge state, so a same-cycle pop never frees a slot
  assign tx_push  = wr_tx && !halted && !tx_full;
  assign tx_pop   = !tx_empty && tx_ready;
  assign rx_push  = rx_valid && !rx_full;
  assign rx_pop   = wr_ctrl && data_in[0] && !rx_empty;

  assign tx_valid = !tx_empty;
  assign rx_ready = !rx_full;
  assign tx_data  = tx_mem[tx_rp[TX_AW-1:0]];
  assign rx_head  = rx_mem[rx_rp[RX_AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_wp <= '0;
      tx_rp <= '0;
      for (int unsigned i = 0; i < TX_DEPTH; i++) tx_mem[i] <= '0;
    end else begin
      if (tx_push) begin
        tx_mem[tx_wp[TX_AW-1:0]] <= data_in;
        tx_wp <= tx_wp + TX_PW'(1);
      end
      if (tx_pop) tx_rp <= tx_rp + TX_PW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_wp <= '0;
      rx_rp <= '0;
      for (int unsigned i = 0; i < RX_DEPTH; i++) rx_mem[i] <= '0;
    end else begin
      if (rx_push) begin
        rx_mem[rx_wp[RX_AW-1:0]] <= rx_data;
        rx_wp <= rx_wp + RX_PW'(1);
      end
      if (rx_pop) rx_rp <= rx_rp + RX_PW'(1);
    end
  end

  // Sticky flags: overflow only counts while not halted; halt clears on reset only
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_ovf <= 1'b0;
      halted <= 1'b0;
    end else begin
      if (wr_tx && !halted && tx_full) tx_ovf <= 1'b1;
      else if (wr_ctrl && data_in[1]) tx_ovf <= 1'b0;
      if (wr_halt) halted <= 1'b1;
    end
  end

  always_comb begin
    data_out = '0;
    if (hit) begin
      case (address[11:2])
        REG_STATUS:  data_out = {27'b0, halted, tx_ovf, !rx_empty, tx_full, tx_empty};
        REG_RX_DATA: data_out = rx_empty ? 32'h0 : rx_head;
        REG_HALT:    data_out = {31'b0, halted};
        default:     data_out = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_port.sv
// Directed bench for mmio_port: queue-based reference model checked every
// negative edge, plus hand-computed expectations along the directed sequence.
module tb_mmio_port;

  localparam int unsigned TX_DEPTH = 4;
  localparam int unsigned RX_DEPTH = 4;

  logic        clk;
  logic        reset;
  logic [31:0] address;
  logic [31:0] data_in;
  logic        we;
  logic [31:0] data_out;
  logic        hit;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        halted;

  mmio_port #(.TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH)) dut (
    .clk(clk), .reset(reset), .address(address), .data_in(data_in), .we(we),
    .data_out(data_out), .hit(hit), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain queues and flags
  logic [31:0] txq[$];
  logic [31:0] rxq[$];
  bit          m_ovf, m_halt;
  bit          m_tpush, m_tpop, m_rpush, m_rpop, m_wr;
  logic [11:0] m_a;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      txq.delete();
      rxq.delete();
      m_ovf  = 0;
      m_halt = 0;
    end else begin
      m_a     = address[11:0] & 12'hFFC;
      m_wr    = we && address[11];
      m_tpop  = (txq.size() > 0) && tx_ready;
      m_tpush = 0;
      if (m_wr && m_a == 12'h800 && !m_halt) begin
        if (txq.size() == TX_DEPTH) m_ovf = 1;
        else m_tpush = 1;
      end
      m_rpush = rx_valid && (rxq.size() < RX_DEPTH);
      m_rpop  = m_wr && m_a == 12'h80C && data_in[0] && (rxq.size() > 0);
      if (m_wr && m_a == 12'h80C && data_in[1]) m_ovf = 0;
      if (m_wr && m_a == 12'hFFC) m_halt = 1;
      if (m_tpop) void'(txq.pop_front());
      if (m_tpush) txq.push_back(data_in);
      if (m_rpop) void'(rxq.pop_front());
      if (m_rpush) rxq.push_back(rx_data);
    end
  end

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    logic [11:0] w;
    w = a[11:0] & 12'hFFC;
    if (!a[11]) return 32'h0;
    case (w)
      12'h804: return {27'b0, m_halt, m_ovf, rxq.size() > 0,
                       txq.size() == TX_DEPTH, txq.size() == 0};
      12'h808: return (rxq.size() > 0) ? rxq[0] : 32'h0;
      12'hFFC: return {31'b0, m_halt};
      default: return 32'h0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      chk("hit", {31'b0, hit}, {31'b0, address[11]});
      chk("data_out", data_out, exp_read(address));
      chk("tx_valid", {31'b0, tx_valid}, {31'b0, txq.size() > 0});
      if (txq.size() > 0) chk("tx_data", tx_data, txq[0]);
      chk("rx_ready", {31'b0, rx_ready}, {31'b0, rxq.size() < RX_DEPTH});
      chk("halted", {31'b0, halted}, {31'b0, m_halt});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    address = a;
    data_in = d;
    we      = 1'b1;
    tick();
    we      = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
    address = a;
    we      = 1'b0;
    #1;
    chk(name, data_out, exp);
  endtask

  task automatic rx_push(input logic [31:0] d);
    rx_data  = d;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; address = '0; data_in = '0; we = 1'b0;
    tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    chk("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
    chk("rst_rx_ready", {31'b0, rx_ready}, 32'h1);
    chk("rst_tx_data", tx_data, 32'h0);
    rd(32'h804, 32'h1, "rst_status");

    // TX fill and overflow
    for (int i = 0; i < 5; i++) wr(32'h800, 32'hA0 + 32'(i));
    rd(32'h804, 32'hA, "tx_full_ovf_status");
    rd(32'h800, 32'h0, "tx_data_reads_zero");
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("tx_drain_data", tx_data, 32'hA0 + 32'(i));
      tick();
    end
    chk("tx_drain_empty", {31'b0, tx_valid}, 32'h0);
    tx_ready = 1'b0;
    rd(32'h804, 32'h9, "tx_empty_ovf_status");
    wr(32'h80C, 32'h2);
    rd(32'h804, 32'h1, "ovf_cleared");

    // TX full with simultaneous drain
    for (int i = 0; i < 4; i++) wr(32'h800, 32'hB0 + 32'(i));
    tx_ready = 1'b1;
    wr(32'h800, 32'hBB);
    tx_ready = 1'b0;
    chk("full_drain_head", tx_data, 32'hB1);
    rd(32'h804, 32'h8, "full_drain_status");
    tx_ready = 1'b1;
    tick(); tick(); tick();
    chk("full_drain_empty", {31'b0, tx_valid}, 32'h0);
    tx_ready = 1'b0;
    wr(32'h80C, 32'h2);

    // RX path
    rx_push(32'h11);
    rx_push(32'h22);
    for (int i = 0; i < 3; i++) begin
      rd(32'h808, 32'h11, "rx_hold_read");
      tick();
    end
    rd(32'h804, 32'h5, "rx_nonempty_status");
    wr(32'h80C, 32'h1);
    rd(32'h808, 32'h22, "rx_second");
    wr(32'h80C, 32'h1);
    rd(32'h808, 32'h0, "rx_empty_read");
    rd(32'h804, 32'h1, "rx_empty_status");
    wr(32'h80C, 32'h1);
    rx_push(32'h33);
    rd(32'h808, 32'h33, "rx_after_empty_pop");
    wr(32'h80C, 32'h1);

    // RX full: an offer while full is refused even with a same-cycle pop
    for (int i = 0; i < 4; i++) rx_push(32'hE0 + 32'(i));
    chk("rx_full_ready", {31'b0, rx_ready}, 32'h0);
    rx_data = 32'h99; rx_valid = 1'b1;
    wr(32'h80C, 32'h1);
    rx_valid = 1'b0;
    chk("rx_after_pop_ready", {31'b0, rx_ready}, 32'h1);
    rd(32'h808, 32'hE1, "rx_full_head");
    for (int i = 0; i < 3; i++) wr(32'h80C, 32'h1);
    rd(32'h808, 32'h0, "rx_full_offer_dropped");

    // RX wrap-around with overlapped push/pop
    rx_push(32'h100);
    for (int i = 1; i < 10; i++) begin
      rd(32'h808, 32'h100 + 32'(i - 1), "rx_wrap_head");
      rx_data = 32'h100 + 32'(i); rx_valid = 1'b1;
      wr(32'h80C, 32'h1);
      rx_valid = 1'b0;
    end
    rd(32'h808, 32'h109, "rx_wrap_last");
    wr(32'h80C, 32'h1);
    rd(32'h804, 32'h1, "rx_wrap_empty");

    // Out-of-window and unmapped accesses
    wr(32'h0000_0800 & 32'h7FF, 32'hDEAD);
    rd(32'h7FC, 32'h0, "miss_read");
    chk("miss_hit", {31'b0, hit}, 32'h0);
    wr(32'h810, 32'h1);
    rd(32'h810, 32'h0, "unmapped_read");
    rd(32'h804, 32'h1, "unmapped_no_effect");

    // Halt
    for (int i = 0; i < 4; i++) wr(32'h800, 32'hD0 + 32'(i));
    wr(32'hFFC, 32'h0);
    chk("halt_set", {31'b0, halted}, 32'h1);
    rd(32'hFFC, 32'h1, "halt_read");
    rd(32'h804, 32'h12, "halt_status");
    wr(32'h800, 32'hCC);
    rd(32'h804, 32'h12, "halt_tx_ignored");
    rx_push(32'h55);
    rd(32'h808, 32'h55, "halt_rx_push");
    wr(32'h80C, 32'h1);
    rd(32'h808, 32'h0, "halt_rx_pop");
    tx_ready = 1'b1;
    chk("halt_tx_head", tx_data, 32'hD0);
    for (int i = 0; i < 4; i++) tick();
    chk("halt_tx_drained", {31'b0, tx_valid}, 32'h0);
    tx_ready = 1'b0;
    rd(32'h804, 32'h11, "halt_drained_status");

    // Mid-cycle reset discards state without a clock edge
    wr(32'h800, 32'h44);
    rx_push(32'h66);
    address = 32'h804;
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_tx_valid", {31'b0, tx_valid}, 32'h0);
    chk("mid_rst_rx_ready", {31'b0, rx_ready}, 32'h1);
    chk("mid_rst_halted", {31'b0, halted}, 32'h0);
    chk("mid_rst_status", data_out, 32'h1);
    chk("mid_rst_tx_data", tx_data, 32'h0);
    #3 reset = 1'b0;
    wr(32'h800, 32'h77);
    chk("post_rst_tx_valid", {31'b0, tx_valid}, 32'h1);
    chk("post_rst_tx_data", tx_data, 32'h77);
    rd(32'h808, 32'h0, "post_rst_rx_empty");
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    rd(32'h804, 32'h1, "post_rst_status");
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mmio_port.md
# mmio_port

Memory-mapped I/O responder on the core's data bus, covering the `address[11]==1` window (0x800–0xFFF). Core stores to the window push words into a TX FIFO drained by a host-side valid/ready stream. A host-side stream fills an RX FIFO that the core polls and pops by register access. A store to 0xFFC latches a sticky `halted` flag that tells the environment to end the run. The top level muxes `data_out` onto the core's read-data bus whenever `hit` is high.

## Interface
- `TX_DEPTH`, 4: TX FIFO depth in words; power of two, ≥2.
- `RX_DEPTH`, 4: RX FIFO depth in words; power of two, ≥2.

- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `address` in 32: core bus address; only `address[11:0]` decoded, with `address[11]` as the window select.
- `data_in` in 32: core write data.
- `we` in 1: core write strobe, sampled at rising edge.
- `data_out` out 32: read data, combinational from `address` and current state.
- `hit` out 1: `address[11]`, combinational.
- `tx_data` out 32: TX FIFO head.
- `tx_valid` out 1: TX FIFO non-empty.
- `tx_ready` in 1: host accepts `tx_data` at the edge where both `tx_valid` and `tx_ready` are high.
- `rx_data` in 32: host word into the RX FIFO.
- `rx_valid` in 1: host offers `rx_data`.
- `rx_ready` out 1: RX FIFO not full; the word is accepted at the edge where both `rx_valid` and `rx_ready` are high.
- `halted` out 1: sticky halt flag.

## Operation
All registers are word-aligned and decoded on `address[11:2]` with `address[11]==1`.

- **0x800 TX_DATA**
  - Write: push `data_in` if TX is not full and `halted==0`.
  - If TX is full, the write is dropped and `tx_ovf` is set (sticky).
  - Read returns 0.
- **0x804 STATUS** (read-only): bit0 `tx_empty`, bit1 `tx_full`, bit2 `rx_nonempty`, bit3 `tx_ovf`, bit4 `halted`; bits 31:5 read as 0.
- **0x808 RX_DATA** (read-only): RX head, or 0 if RX is empty. Reads are non-destructive, because the core may hold an address for several cycles.
- **0x80C RX_CTRL**
  - Write with `data_in[0]=1`: pop RX if non-empty; no effect if empty.
  - Write with `data_in[1]=1`: clear `tx_ovf`.
  - Both bits may be set in one write.
  - Read returns 0.
- **0xFFC HALT**: any write sets `halted`. Only `reset` clears it. Read returns `{31'b0, halted}`.
- All other window addresses read as 0 and ignore writes.
- When `hit==0`, `data_out` is 0 and writes are ignored.
- After `halted` is set, TX_DATA writes are ignored and do not set `tx_ovf`. The RX path, RX_CTRL, and host TX draining keep working.

FIFO behaviour:
- Each FIFO is circular, with pointers one bit wider than log2(DEPTH) for full/empty detection. Pointers wrap modulo 2·DEPTH.
- **Full is evaluated before same-cycle pops.** A TX write while full is dropped even if the host drains in the same cycle. An RX offer while full is not accepted (`rx_ready==0`) even if the core pops in the same cycle.
- Push and pop in the same cycle on a non-full, non-empty FIFO: both take effect; occupancy is unchanged.
- Push to an empty FIFO: the head becomes visible the next cycle. There is no fall-through in the same cycle.

## Timing
- Reset values:
  - all FIFO pointers 0;
  - `tx_valid=0`, `rx_ready=1`;
  - `tx_ovf=0`, `halted=0`;
  - `tx_data` = 0 (storage cleared);
  - `data_out` follows the decode, so STATUS reads 0x1.
- Write latency: a core write at edge N is visible in `tx_valid`, `STATUS`, and `halted` immediately after edge N.
- Host RX handshake at edge N: `rx_nonempty` and `RX_DATA` update after edge N.
- Host TX handshake at edge N: the next head, or `tx_valid=0`, appears after edge N.
- `reset` asserted mid-transfer: FIFO contents are discarded and outputs return to reset values without waiting for a clock edge. The first edge after deassertion behaves as a normal cycle.

## Test plan
- **Reset:** pulse `reset` mid-cycle -> `tx_valid=0`, `rx_ready=1`, `halted=0`, STATUS read = 0x1, with no clock edge needed.
- **TX fill/overflow:**
  - With `tx_ready=0`, write 0xA0..0xA4 to 0x800 -> STATUS = 0xA after the 5th write. The FIFO holds A0..A3; A4 is dropped.
  - Set `tx_ready=1` -> `tx_data` shows A0, A1, A2, A3 on consecutive cycles, then `tx_valid=0`.
  - Write 0x2 to 0x80C -> `tx_ovf` clears.
- **TX full with simultaneous drain:** TX full, core writes 0xBB while the host handshakes -> 0xBB is dropped, `tx_ovf=1`, occupancy is 3.
- **RX path:**
  - Host pushes 0x11, 0x22 -> RX_DATA reads 0x11 repeatedly across 3 cycles, and STATUS bit2 = 1.
  - Write 0x1 to 0x80C -> RX_DATA = 0x22. Pop again -> RX_DATA = 0, bit2 = 0.
  - Pop while empty -> no pointer change.
- **RX wrap-around:** push and pop 10 words 0x100..0x109 interleaved -> each word reads back in order, and full/empty are correct across two pointer wraps.
- **Halt:**
  - Write to 0xFFC -> `halted=1` after the edge, and a 0xFFC read returns 1.
  - A subsequent TX_DATA write is ignored with `tx_ovf` unchanged, while RX push/pop still work.
  - Reset clears `halted`.
